// File: rtl/axi4_pkg.sv
// Shared AXI4 write-path definitions: response codes, beat geometry and the
// write-channel state encoding.
package axi4_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         BEAT_BYTES  = 4;
  localparam logic [2:0] LEGAL_SIZE  = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } wr_state_t;

endpackage

// File: rtl/axi4_if.sv
// AXI4 write-channel bundle (AW/W/B) with master and slave views.
interface axi4_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  WLAST;
  logic                  WVALID;
  logic                  WREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWVALID, WDATA, WLAST, WVALID, BREADY,
    input  AWREADY, WREADY, BRESP, BVALID
  );

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWVALID, WDATA, WLAST, WVALID, BREADY,
    output AWREADY, WREADY, BRESP, BVALID
  );

endinterface

// File: rtl/axi4_burst_check.sv
// Combinational legality check of an INCR burst request: size, alignment,
// 4KB boundary / address wrap, and fit inside the word memory.
module axi4_burst_check
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  output logic                  err
);

  // One extra bit so a burst running off the top of the address space is visible.
  logic [ADDR_WIDTH:0] end_byte;

  assign end_byte = {1'b0, awaddr}
                  + (ADDR_WIDTH+1)'((32'(awlen) + 32'd1) * 32'(BEAT_BYTES) - 32'd1);

  assign err = (awsize != LEGAL_SIZE)
            || (awaddr[1:0] != 2'b00)
            || end_byte[ADDR_WIDTH]
            || (end_byte[ADDR_WIDTH-1:12] != awaddr[ADDR_WIDTH-1:12])
            || (int'(end_byte[ADDR_WIDTH:2]) >= MEM_DEPTH);

endmodule

// File: rtl/axi4_write_slave.sv
// AXI4 write slave: turns one outstanding INCR burst into single-word memory
// writes; illegal bursts are drained silently and answered with SLVERR.
module axi4_write_slave
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  localparam int MEM_AW    = $clog2(MEM_DEPTH)
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  axi4_if.slave                 axi,
  output logic                  mem_we,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata
);

  wr_state_t         state_reg, state_next;
  logic [MEM_AW-1:0] addr_reg, addr_next;
  logic [7:0]        len_reg, len_next;
  logic [7:0]        beat_cnt_reg, beat_cnt_next;
  logic              err_reg, err_next;
  logic [1:0]        bresp_reg, bresp_next;
  logic              burst_err;
  logic              last_beat;
  logic              wlast_bad;

  axi4_burst_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_check (
    .awaddr (axi.AWADDR),
    .awlen  (axi.AWLEN),
    .awsize (axi.AWSIZE),
    .err    (burst_err)
  );

  assign last_beat = (beat_cnt_reg == len_reg);
  assign wlast_bad = (axi.WLAST != last_beat);

  assign axi.AWREADY = (state_reg == IDLE);
  assign axi.WREADY  = (state_reg == DATA);
  assign axi.BVALID  = (state_reg == RESP);
  assign axi.BRESP   = bresp_reg;
  assign mem_addr    = addr_reg;
  assign mem_wdata   = axi.WDATA;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      len_reg      <= '0;
      beat_cnt_reg <= '0;
      err_reg      <= 1'b0;
      bresp_reg    <= RESP_OKAY;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      len_reg      <= len_next;
      beat_cnt_reg <= beat_cnt_next;
      err_reg      <= err_next;
      bresp_reg    <= bresp_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    len_next      = len_reg;
    beat_cnt_next = beat_cnt_reg;
    err_next      = err_reg;
    bresp_next    = bresp_reg;
    mem_we        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (axi.AWVALID) begin
          state_next    = DATA;
          addr_next     = axi.AWADDR[MEM_AW+1:2];
          len_next      = axi.AWLEN;
          beat_cnt_next = '0;
          err_next      = burst_err;
        end
      end
      DATA: begin
        if (axi.WVALID) begin
          // A WLAST mismatch only suppresses later beats; this one still goes out.
          mem_we    = !err_reg;
          addr_next = addr_reg + 1'b1;
          err_next  = err_reg | wlast_bad;
          if (last_beat) begin
            state_next = RESP;
            bresp_next = (err_reg | wlast_bad) ? RESP_SLVERR : RESP_OKAY;
          end else begin
            beat_cnt_next = beat_cnt_reg + 1'b1;
          end
        end
      end
      RESP: begin
        if (axi.BREADY) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
